vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Generates 640x480@60Hz VGA raster timing from the 25 MHz pixel clock.
//   Drives DrawX/DrawY/blank into the full-screen sprite/menu renderers, which
//   read ROM on negedge and register RGB on the next posedge (1 cycle).
//   Also provides hs/vs/blank delayed to line up with that registered RGB,
//   plus frame/line strobes and a frame counter for animation logic.
// PARAMETERS
//   H_VISIBLE   640  active pixels per line
//   H_FRONT     16   horizontal front porch (pixels)
//   H_SYNC      96   horizontal sync width (pixels)
//   H_BACK      48   horizontal back porch (pixels)
//   V_VISIBLE   480  active lines per frame
//   V_FRONT     10   vertical front porch (lines)
//   V_SYNC      2    vertical sync width (lines)
//   V_BACK      33   vertical back porch (lines)
//   PIPE_DELAY  1    cycles of delay on hs_d/vs_d/blank_d (1..4)
//   FRAME_W     16   width of frame_count
// PORTS
//   vga_clk      in   1        pixel clock; all logic on posedge
//   reset        in   1        synchronous, active-high
//   DrawX        out  10       current pixel column, 0..H_TOTAL-1
//   DrawY        out  10       current line, 0..V_TOTAL-1
//   blank        out  1        1 = active video (DrawX<640 && DrawY<480), 0 = blanking
//   hs           out  1        horizontal sync, active low, aligned with DrawX
//   vs           out  1        vertical sync, active low, aligned with DrawY
//   hs_d         out  1        hs delayed by PIPE_DELAY cycles (to pins)
//   vs_d         out  1        vs delayed by PIPE_DELAY cycles (to pins)
//   blank_d      out  1        blank delayed by PIPE_DELAY cycles
//   line_start   out  1        1-cycle pulse when DrawX==0
//   frame_start  out  1        1-cycle pulse when DrawX==0 && DrawY==0
//   frame_count  out  FRAME_W  increments on every frame_start
// BEHAVIOUR
// - H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
// - DrawX/DrawY are the counter registers themselves.
//   - hc: 0..H_TOTAL-1, +1 per clock, wraps to 0.
//   - vc: +1 on each hc wrap; when vc==V_TOTAL-1 and hc wraps, vc wraps to 0.
// - hs, vs, blank, line_start and frame_start are registered.
//   - They are decoded from the next-state counters, so they change on the same edge as DrawX/DrawY.
//   - They are never combinational off the counter outputs.
// - Sync windows:
//   - hs=0 iff H_VISIBLE+H_FRONT <= hc < that + H_SYNC (656..751).
//   - vs=0 iff V_VISIBLE+V_FRONT <= vc < that + V_SYNC (490..491), for the whole line.
// - Reset is synchronous and wins over counting. Values while reset is high and on the first cycle after it:
//   - hc=vc=0, hs=1, vs=1, blank=1.
//   - line_start=0, frame_start=0, frame_count=0.
//   - Every stage of the delay chain = inactive: hs_d=1, vs_d=1, blank_d=0.
// - First cycle after reset release: DrawX=1. Strobes fire only on wraps, never on the reset point.
// - Strobes:
//   - line_start is high for exactly one cycle per line, in the cycle DrawX==0 following a wrap.
//   - frame_start is the same, but only when DrawY is also 0.
// - frame_count increments on the same edge frame_start rises. It wraps 2^FRAME_W-1 -> 0 with no flag.
// - Reset mid-frame: outputs return to reset values on the next edge. No partial sync pulse is stretched.
// - Delayed outputs: *_d equals the undelayed signal PIPE_DELAY edges earlier. During the fill after reset they hold the inactive values above.
// - Elaboration check: $error if PIPE_DELAY<1, PIPE_DELAY>4, or H_TOTAL/V_TOTAL > 1024.
// STRUCTURE
// - Package vga_timing_pkg holds:
//   - the default 640x480 timing constants;
//   - H_TOTAL/V_TOTAL localparam functions;
//   - typedef logic [9:0] coord_t, used by DrawX/DrawY and the renderers.
// - One sub-module, sig_delay_line #(WIDTH, DEPTH, RESET_VAL):
//   - a shift register with synchronous reset;
//   - one instance carries {hs,vs,blank} with RESET_VAL 3'b110.
// TESTING
// - Reset then release, count cycles: DrawX returns to 0 every 800 cycles; frame_start every 420000 cycles.
// - Within line 0: hs low exactly for DrawX 656..751 (96 cycles); blank=1 for DrawX 0..639 only.
// - Full frame: vs low exactly on DrawY 490 and 491 (1600 cycles); blank=0 on all of DrawY 480..524.
// - PIPE_DELAY=3: hs_d matches hs shifted 3 cycles; hs_d=1, vs_d=1, blank_d=0 for the first 3 cycles after reset.
// - Assert reset at DrawX=700, DrawY=490 (hs, vs both low): next edge gives DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_count=0.
// - FRAME_W=2, run 5 frames: frame_count sequence 1,2,3,0,1; exactly one frame_start per frame, none at reset release.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: default 640x480@60Hz constants,
// total-count helper and the coordinate type used by the renderers.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // Largest count a 10-bit coordinate can represent
  localparam int COORD_LIMIT = 1024;

  // Total pixels per line or lines per frame
  function automatic int calc_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/sig_delay_line.sv
// Fixed-depth shift register with synchronous reset. Every stage resets to
// RESET_VAL so the output holds that value while the chain refills.
module sig_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  // Shift din through DEPTH stages; reset loads every stage with RESET_VAL
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= RESET_VAL;
      end
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. DrawX/DrawY are the raw counters; sync, blank
// and strobes are registered from the next-state counters so they change on
// the same edge as the coordinates. hs/vs/blank also go through a short delay
// line to line up with RGB registered one or more cycles later.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int PIPE_DELAY = 1,
  parameter int FRAME_W    = 16
) (
  input  logic               vga_clk,
  input  logic               reset,
  output logic [9:0]         DrawX,
  output logic [9:0]         DrawY,
  output logic               blank,
  output logic               hs,
  output logic               vs,
  output logic               hs_d,
  output logic               vs_d,
  output logic               blank_d,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = calc_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = calc_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
    $error("vga_timing_gen: PIPE_DELAY must be 1..4");
  end
  if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit coordinate range");
  end

  coord_t     hc;
  coord_t     vc;
  coord_t     hc_next;
  coord_t     vc_next;
  logic [2:0] sync_delayed;

  // Next raster position: hc wraps each line, vc advances on hc wrap
  always_comb begin
    hc_next = hc + 10'd1;
    vc_next = vc;
    if (hc == H_LAST) begin
      hc_next = '0;
      vc_next = (vc == V_LAST) ? '0 : vc + 10'd1;
    end
  end

  // Counters plus sync/blank/strobe decode of the next position; reset wins
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      hc          <= hc_next;
      vc          <= vc_next;
      hs          <= !((hc_next >= HS_START) && (hc_next < HS_END));
      vs          <= !((vc_next >= VS_START) && (vc_next < VS_END));
      blank       <= (hc_next < H_VIS) && (vc_next < V_VIS);
      line_start  <= (hc_next == '0);
      frame_start <= (hc_next == '0) && (vc_next == '0);
      if ((hc_next == '0) && (vc_next == '0)) begin
        frame_count <= frame_count + FRAME_W'(1);
      end
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

  sig_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (3'b110)
  ) u_sync_delay (
    .vga_clk (vga_clk),
    .reset   (reset),
    .din     ({hs, vs, blank}),
    .dout    (sync_delayed)
  );

  assign hs_d    = sync_delayed[2];
  assign vs_d    = sync_delayed[1];
  assign blank_d = sync_delayed[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. A full-size 640x480 instance with
// PIPE_DELAY=3 covers line timing and the delay line; a tiny-raster instance
// (15x10, FRAME_W=2) covers vertical sync, frame strobes, counter wrap and a
// mid-frame reset inside a short run.
module tb_vga_timing_gen;

  localparam int K_END = 1736;

  logic       vga_clk;
  logic       reset;

  logic [9:0] bDrawX, bDrawY;
  logic       bBlank, bHs, bVs, bHsD, bVsD, bBlankD, bLineStart, bFrameStart;
  logic [15:0] bFrameCount;

  logic [9:0] sDrawX, sDrawY;
  logic       sBlank, sHs, sVs, sHsD, sVsD, sBlankD, sLineStart, sFrameStart;
  logic [1:0] sFrameCount;

  int totalChecks = 0;
  int badChecks   = 0;

  int bXYErr = 0, bHsLow = 0, bHsFirst = -1, bHsLast = -1;
  int bBlankCnt = 0, bBlankFirst = -1, bBlankLast = -1;
  int bLsCnt = 0, bLsBad = 0, bFsCnt = 0, bFillBad = 0, bShiftBad = 0;
  int sXYErr = 0, sVsLow = 0, sVsBad = 0, sBlankCnt = 0, sBlankBad = 0;
  int sFsCnt = 0, sFsBad = 0;
  logic [1:0] fcSeq [5];
  logic hsHist [0:K_END];
  logic vsHist [0:K_END];
  logic blankHist [0:K_END];

  vga_timing_gen #(
    .PIPE_DELAY (3),
    .FRAME_W    (16)
  ) dutBig (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (bDrawX),
    .DrawY       (bDrawY),
    .blank       (bBlank),
    .hs          (bHs),
    .vs          (bVs),
    .hs_d        (bHsD),
    .vs_d        (bVsD),
    .blank_d     (bBlankD),
    .line_start  (bLineStart),
    .frame_start (bFrameStart),
    .frame_count (bFrameCount)
  );

  vga_timing_gen #(
    .H_VISIBLE  (8),
    .H_FRONT    (2),
    .H_SYNC     (3),
    .H_BACK     (2),
    .V_VISIBLE  (4),
    .V_FRONT    (1),
    .V_SYNC     (2),
    .V_BACK     (3),
    .PIPE_DELAY (1),
    .FRAME_W    (2)
  ) dutSmall (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (sDrawX),
    .DrawY       (sDrawY),
    .blank       (sBlank),
    .hs          (sHs),
    .vs          (sVs),
    .hs_d        (sHsD),
    .vs_d        (sVsD),
    .blank_d     (sBlankD),
    .line_start  (sLineStart),
    .frame_start (sFrameStart),
    .frame_count (sFrameCount)
  );

  // 25 MHz pixel clock
  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  // Drive reset and hold it for a number of clock cycles, ending on a negedge
  task automatic applyStimulus(input logic rstVal, input int cycles);
    reset = rstVal;
    repeat (cycles) @(negedge vga_clk);
  endtask

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  // Main sequence: reset state, free run with per-cycle bookkeeping, summary checks
  initial begin
    applyStimulus(1'b1, 4);

    checkOutput("rst_drawx",      bDrawX, 0);
    checkOutput("rst_drawy",      bDrawY, 0);
    checkOutput("rst_hs",         bHs, 1);
    checkOutput("rst_vs",         bVs, 1);
    checkOutput("rst_blank",      bBlank, 1);
    checkOutput("rst_line_start", bLineStart, 0);
    checkOutput("rst_frame_start", bFrameStart, 0);
    checkOutput("rst_frame_count", bFrameCount, 0);
    checkOutput("rst_hs_d",       bHsD, 1);
    checkOutput("rst_vs_d",       bVsD, 1);
    checkOutput("rst_blank_d",    bBlankD, 0);

    hsHist[0]    = bHs;
    vsHist[0]    = bVs;
    blankHist[0] = bBlank;
    reset = 1'b0;

    for (int k = 1; k <= K_END; k++) begin
      @(negedge vga_clk);

      // Full-size raster
      if (int'(bDrawX) != k % 800) bXYErr++;
      if (int'(bDrawY) != k / 800) bXYErr++;
      if (bDrawY == 10'd1) begin
        if (!bHs) begin
          bHsLow++;
          if (bHsFirst < 0) bHsFirst = int'(bDrawX);
          bHsLast = int'(bDrawX);
        end
        if (bBlank) begin
          bBlankCnt++;
          if (bBlankFirst < 0) bBlankFirst = int'(bDrawX);
          bBlankLast = int'(bDrawX);
        end
      end
      if (bLineStart) begin
        bLsCnt++;
        if (bDrawX != 10'd0) bLsBad++;
      end
      if (bFrameStart) bFsCnt++;
      hsHist[k]    = bHs;
      vsHist[k]    = bVs;
      blankHist[k] = bBlank;
      if (k < 3) begin
        if (bHsD !== 1'b1 || bVsD !== 1'b1 || bBlankD !== 1'b0) bFillBad++;
      end else begin
        if (bHsD !== hsHist[k-3] || bVsD !== vsHist[k-3] ||
            bBlankD !== blankHist[k-3]) bShiftBad++;
      end

      // Tiny raster: 15 pixels x 10 lines, hs low x 10..12, vs low y 5..6
      if (int'(sDrawX) != k % 15) sXYErr++;
      if (int'(sDrawY) != (k / 15) % 10) sXYErr++;
      if (!sVs) begin
        if (sDrawY < 10'd5 || sDrawY > 10'd6) sVsBad++;
        if (k >= 150 && k < 300) sVsLow++;
      end
      if (sBlank && k >= 150 && k < 300) sBlankCnt++;
      if (sBlank != ((sDrawX < 10'd8) && (sDrawY < 10'd4))) sBlankBad++;
      if (sFrameStart) begin
        sFsCnt++;
        if (k % 150 != 0 || sDrawX != 10'd0 || sDrawY != 10'd0) sFsBad++;
        if (sFsCnt <= 5) fcSeq[sFsCnt-1] = sFrameCount;
      end
      if (k == 1) begin
        checkOutput("first_drawx", bDrawX, 1);
        checkOutput("first_line_start", bLineStart, 0);
        checkOutput("first_frame_start", sFrameStart, 0);
      end
    end

    checkOutput("big_xy_sequence", bXYErr, 0);
    checkOutput("hs_low_count",    bHsLow, 96);
    checkOutput("hs_low_first",    bHsFirst, 656);
    checkOutput("hs_low_last",     bHsLast, 751);
    checkOutput("blank_count",     bBlankCnt, 640);
    checkOutput("blank_first",     bBlankFirst, 0);
    checkOutput("blank_last",      bBlankLast, 639);
    checkOutput("line_start_count", bLsCnt, 2);
    checkOutput("line_start_pos",  bLsBad, 0);
    checkOutput("big_frame_start", bFsCnt, 0);
    checkOutput("delay_fill",      bFillBad, 0);
    checkOutput("delay_shift",     bShiftBad, 0);

    checkOutput("small_xy_sequence", sXYErr, 0);
    checkOutput("vs_low_count",    sVsLow, 30);
    checkOutput("vs_low_lines",    sVsBad, 0);
    checkOutput("small_blank_count", sBlankCnt, 32);
    checkOutput("small_blank_window", sBlankBad, 0);
    checkOutput("frame_start_count", sFsCnt, 11);
    checkOutput("frame_start_pos", sFsBad, 0);
    checkOutput("frame_count_1",   fcSeq[0], 1);
    checkOutput("frame_count_2",   fcSeq[1], 2);
    checkOutput("frame_count_3",   fcSeq[2], 3);
    checkOutput("frame_count_4",   fcSeq[3], 0);
    checkOutput("frame_count_5",   fcSeq[4], 1);

    // Tiny raster now sits at x=11, y=5 with both syncs low
    checkOutput("pre_rst_drawx", sDrawX, 11);
    checkOutput("pre_rst_drawy", sDrawY, 5);
    checkOutput("pre_rst_hs",    sHs, 0);
    checkOutput("pre_rst_vs",    sVs, 0);
    checkOutput("pre_rst_frame_count", sFrameCount, 3);

    applyStimulus(1'b1, 1);
    checkOutput("mid_rst_drawx", sDrawX, 0);
    checkOutput("mid_rst_drawy", sDrawY, 0);
    checkOutput("mid_rst_hs",    sHs, 1);
    checkOutput("mid_rst_vs",    sVs, 1);
    checkOutput("mid_rst_blank", sBlank, 1);
    checkOutput("mid_rst_frame_count", sFrameCount, 0);
    checkOutput("mid_rst_line_start", sLineStart, 0);
    checkOutput("mid_rst_hs_d",  sHsD, 1);
    checkOutput("mid_rst_vs_d",  sVsD, 1);
    checkOutput("mid_rst_blank_d", sBlankD, 0);
    checkOutput("mid_rst_big_drawx", bDrawX, 0);

    applyStimulus(1'b0, 1);
    checkOutput("rerelease_drawx", sDrawX, 1);
    checkOutput("rerelease_frame_start", sFrameStart, 0);
    checkOutput("rerelease_big_drawx", bDrawX, 1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
